norm_shift_pipe: RTL
====================

// Module: norm_shift_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined mantissa shifter for the FP adder datapath.
//  Three modes: explicit left shift, right shift with sticky (exponent alignment),
//  and auto-normalise (leading-one detect + left shift, count reported).
//  Sits between mantissa add/sub and rounding. Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  11  mantissa width incl. hidden bit (11 = binary16)
//  SHW    $clog2(WIDTH+1)  shift-amount width (localparam, derived; 4 at default)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_data    in   WIDTH  operand
//  in_mode    in   2      00=SHL, 01=SHR, 10=NORM, 11=pass-through (amt ignored)
//  in_amt     in   SHW    shift amount (SHL/SHR only)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  shifted result
//  out_amt    out  SHW    shift actually applied (NORM: leading-zero count)
//  out_sticky out  1      SHR: OR of all bits shifted out; else 0
//  out_zero   out  1      in_data was all zero
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids, out_valid, out_data, out_amt,
//    out_sticky, out_zero clear to 0; in_ready is 1 the first cycle after release.
//    Reset mid-operation discards all in-flight beats; no partial result emitted.
//  - Handshake: beat transfers on in_valid&in_ready; result on out_valid&out_ready.
//    out_* held stable while out_valid&!out_ready. in_ready is combinational:
//    in_ready = !s1_valid | s1_advance; s1_advance = !s2_valid | out_ready.
//    Full throughput (1 beat/cycle) when out_ready=1; capacity 2 beats.
//  - Latency: fixed 2 cycles in->out with no back-pressure.
//  - Stage 1 (registered on accept): resolve effective amount (NORM: amt = LZC of
//    in_data, LZC(0)=WIDTH; pass: amt=0); apply low-order amount bits amt[1:0];
//    accumulate sticky for SHR from bits dropped so far; compute zero flag.
//  - Stage 2 (registered on s1_advance): apply remaining bits amt[SHW-1:2]; finish sticky.
//  - Width rules: shifts fill with 0. amt >= WIDTH: SHL -> data 0; SHR -> data 0,
//    sticky = |in_data. out_amt reports requested amt unclamped.
//  - NORM: out_data[WIDTH-1]=1 for any nonzero input; zero input -> out_data 0,
//    out_amt=WIDTH, out_zero=1. out_sticky always 0 outside SHR.
//  - Simultaneous accept and emit in the same cycle permitted; no bubble inserted.
//  - in_mode/in_amt sampled only on accept; changes while !in_ready ignored.
// TESTING (WIDTH=11)
//  1 SHL in_data=11'h001 amt=3 -> out_data=11'h008, amt=3, sticky=0, 2 cycles later
//  2 SHR in_data=11'h40F amt=4 -> out_data=11'h040, sticky=1; amt=12 -> data 0, sticky 1
//  3 NORM in_data=11'h013 -> out_data=11'h4C0, out_amt=6; NORM 0 -> data 0, amt=11, zero=1
//  4 Back-pressure: out_ready=0, send 3 beats -> in_ready low after 2nd accept;
//    release -> 3 results in order, none lost/duplicated, out_* stable while stalled
//  5 Streaming: in_valid=1, out_ready=1 for 20 random beats -> 1 result/cycle vs model
//  6 Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, no
//    stale result after release; first new beat emerges exactly 2 cycles after accept

Source files
------------

// File: rtl/norm_shift_pipe.sv
// Two-stage mantissa shifter for the FP adder: SHL, SHR with sticky, leading-one
// normalise, or pass-through. Stage 1 applies amt[1:0], stage 2 the upper bits.
module norm_shift_pipe #(
    parameter  int WIDTH = 11,
    localparam int SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output logic             out_sticky,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_SHL  = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_NORM = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        mode_e            mode;
        logic             sticky;
        logic             zero;
    } stage_t;

    function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] v);
        lzc = SHW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) lzc = SHW'(WIDTH - 1 - i);
        end
    endfunction

    logic [2:1] vld_pipe_q, vld_pipe_d;
    stage_t     s1_q, s1_d, s2_q, s2_d;
    logic       s1_advance, accept;

    assign s1_advance = !vld_pipe_q[2] | out_ready;
    assign in_ready   = !vld_pipe_q[1] | s1_advance;
    assign accept     = in_valid & in_ready;

    always_comb begin
        vld_pipe_d[1] = accept ? 1'b1 : (s1_advance ? 1'b0 : vld_pipe_q[1]);
        vld_pipe_d[2] = s1_advance ? vld_pipe_q[1] : vld_pipe_q[2];
    end

    // Stage 1: resolve amount, low-order shift, partial sticky.
    logic [SHW-1:0] amt_eff;
    logic [1:0]     lo;
    mode_e          mode;

    always_comb begin
        s1_d    = s1_q;
        mode    = mode_e'(in_mode);
        amt_eff = '0;
        lo      = '0;
        if (accept) begin
            unique case (mode)
                MODE_SHL, MODE_SHR: amt_eff = in_amt;
                MODE_NORM:          amt_eff = lzc(in_data);
                MODE_PASS:          amt_eff = '0;
            endcase
            lo          = amt_eff[1:0];
            s1_d.amt    = amt_eff;
            s1_d.mode   = mode;
            s1_d.zero   = (in_data == '0);
            s1_d.sticky = 1'b0;
            if (mode == MODE_SHR) begin
                s1_d.data   = in_data >> lo;
                s1_d.sticky = |(in_data & ~({WIDTH{1'b1}} << lo));
            end else begin
                s1_d.data   = in_data << lo;
            end
        end
    end

    // Stage 2: upper amount bits; shifts of WIDTH or more drain everything to sticky.
    logic [SHW-1:0] hi;

    always_comb begin
        s2_d = s2_q;
        hi   = {s1_q.amt[SHW-1:2], 2'b00};
        if (s1_advance && vld_pipe_q[1]) begin
            s2_d = s1_q;
            if (s1_q.mode == MODE_SHR) begin
                s2_d.data   = s1_q.data >> hi;
                s2_d.sticky = s1_q.sticky | (|(s1_q.data & ~({WIDTH{1'b1}} << hi)));
            end else begin
                s2_d.data   = s1_q.data << hi;
                s2_d.sticky = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid  = vld_pipe_q[2];
    assign out_data   = s2_q.data;
    assign out_amt    = s2_q.amt;
    assign out_sticky = s2_q.sticky;
    assign out_zero   = s2_q.zero;

endmodule
